mem_gasket_arb: RTL and testbench

Parametrised successor to the fixed three-write/two-read memory gasket. It arbitrates NW write channels and NR read channels onto one memory-controller native port (cmd/wr/rd FIFOs) using round-robin arbitration and per-channel valid/ready handshakes. It honours memc_cmd_full and memc_wr_full backpressure, and tags every read so return data is routed to the issuing channel. This makes the phase-based state input unnecessary, so BLAKE2B, RADIX and COLLISION traffic may overlap.

---
 rtl/mem_gasket_arb.sv | 157 +++++++++++++++
 tb/tb_mem_gasket_arb.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_gasket_arb.sv
// mem_gasket_arb: round-robin arbiter of NW write and NR read channels onto one memory-controller native port
// eclk/rstb: clock, asynchronous active-low reset
// wvalid/wready/waddr/wdata: per-channel write requests, packed AW/DW lanes
// rsend/rready/raddr: per-channel read requests; rdata/rvalid: read return routed by tag
// rd_outstanding/err_orphan: tag FIFO occupancy, sticky return-without-tag flag
// memc_*: controller native cmd/wr/rd FIFO port
module mem_gasket_arb #(
  parameter int NW   = 3,
  parameter int NR   = 2,
  parameter int DW   = 256,
  parameter int AW   = 29,
  parameter int ASH  = 3,
  parameter int TAGD = 16,
  parameter int BL   = 1
) (
  input  logic                  eclk,
  input  logic                  rstb,
  input  logic [NW-1:0]         wvalid,
  output logic [NW-1:0]         wready,
  input  logic [NW*AW-1:0]      waddr,
  input  logic [NW*DW-1:0]      wdata,
  input  logic [NR-1:0]         rsend,
  output logic [NR-1:0]         rready,
  input  logic [NR*AW-1:0]      raddr,
  output logic [DW-1:0]         rdata,
  output logic [NR-1:0]         rvalid,
  output logic [$clog2(TAGD):0] rd_outstanding,
  output logic                  err_orphan,
  input  logic                  memc_cmd_full,
  output logic                  memc_cmd_en,
  output logic [2:0]            memc_cmd_instr,
  output logic [5:0]            memc_cmd_bl,
  output logic [27:0]           memc_cmd_addr,
  output logic                  memc_wr_en,
  output logic                  memc_wr_end,
  output logic [63:0]           memc_wr_mask,
  output logic [511:0]          memc_wr_data,
  input  logic                  memc_wr_full,
  output logic                  memc_rd_en,
  input  logic [511:0]          memc_rd_data,
  input  logic                  memc_rd_empty
);
  localparam int N = NW + NR;
  localparam int IW = $clog2(N);
  localparam int TW = NR > 1 ? $clog2(NR) : 1;
  localparam int PW = $clog2(TAGD) + 1;
  localparam int XW = AW + ASH + 28;
  localparam logic [PW:0] DEPTH = TAGD[PW:0];
  localparam logic [IW-1:0] LAST = IW'(N - 1);
  localparam logic [IW-1:0] FIRST_RD = IW'(NW);
  logic slot_v_q, slot_v_d, slot_rd_q, slot_rd_d;
  logic [27:0] slot_addr_q, slot_addr_d;
  logic [DW-1:0] slot_data_q, slot_data_d;
  logic [TW-1:0] slot_tag_q, slot_tag_d;
  logic [PW-1:0] wp_q, wp_d, rp_q, rp_d, cnt;
  logic [TW-1:0] tag_mem [TAGD];
  logic [IW-1:0] ptr_q, ptr_d, gnt;
  logic gnt_v, fire, push, pop, slot_ok, rd_ok;
  logic [N-1:0] elig, gnt_oh;
  logic [PW:0] occ_n;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_data, rdata_q, rdata_d;
  logic [TW-1:0] sel_tag;
  logic [XW-1:0] addr_x;
  logic [NR-1:0] rvalid_q, rvalid_d;
  logic err_q, err_d;
  logic unused_bits;
  assign cnt = wp_q - rp_q;
  assign fire = slot_v_q & ~memc_cmd_full & (slot_rd_q | ~memc_wr_full);
  assign push = fire & slot_rd_q;
  assign memc_rd_en = ~memc_rd_empty;
  assign pop = memc_rd_en & (cnt != '0);
  // occupancy the tag FIFO will have after this cycle's push/pop; a new read needs room beyond it
  assign occ_n = {1'b0, cnt} + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
  assign rd_ok = occ_n < DEPTH;
  assign slot_ok = ~slot_v_q | fire;
  assign elig = {rsend & {NR{rd_ok}}, wvalid} & {N{slot_ok}};
  // lowest eligible index overall, overridden by the lowest one above the pointer
  always_comb begin
    gnt_v = 1'b0;
    gnt = '0;
    for (int i = N - 1; i >= 0; i--) if (elig[i]) begin
      gnt_v = 1'b1;
      gnt = IW'(i);
    end
    for (int i = N - 1; i >= 0; i--) if (elig[i] && IW'(i) > ptr_q) gnt = IW'(i);
  end
  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    sel_tag = '0;
    for (int i = 0; i < NW; i++) if (gnt == IW'(i)) begin
      sel_addr = waddr[i*AW +: AW];
      sel_data = wdata[i*DW +: DW];
    end
    for (int i = 0; i < NR; i++) if (gnt == IW'(NW + i)) begin
      sel_addr = raddr[i*AW +: AW];
      sel_tag = TW'(i);
    end
  end
  assign addr_x = XW'(sel_addr) << ASH;
  assign gnt_oh = gnt_v ? N'(1) << gnt : '0;
  assign wready = gnt_oh[NW-1:0];
  assign rready = gnt_oh[N-1:NW];
  assign ptr_d = gnt_v ? gnt : ptr_q;
  assign slot_v_d = gnt_v | (slot_v_q & ~fire);
  assign slot_rd_d = gnt_v ? gnt >= FIRST_RD : slot_rd_q;
  assign slot_addr_d = gnt_v ? addr_x[27:0] : slot_addr_q;
  assign slot_data_d = gnt_v ? sel_data : slot_data_q;
  assign slot_tag_d = gnt_v ? sel_tag : slot_tag_q;
  assign wp_d = wp_q + PW'(push);
  assign rp_d = rp_q + PW'(pop);
  assign rvalid_d = pop ? NR'(1) << tag_mem[rp_q[PW-2:0]] : '0;
  assign rdata_d = pop ? memc_rd_data[DW-1:0] : rdata_q;
  assign err_d = err_q | (memc_rd_en & (cnt == '0));
  always_ff @(posedge eclk or negedge rstb) begin
    if (!rstb) begin
      slot_v_q <= 1'b0;
      slot_rd_q <= 1'b0;
      slot_addr_q <= '0;
      slot_data_q <= '0;
      slot_tag_q <= '0;
      wp_q <= '0;
      rp_q <= '0;
      ptr_q <= LAST;
      rvalid_q <= '0;
      rdata_q <= '0;
      err_q <= 1'b0;
    end else begin
      slot_v_q <= slot_v_d;
      slot_rd_q <= slot_rd_d;
      slot_addr_q <= slot_addr_d;
      slot_data_q <= slot_data_d;
      slot_tag_q <= slot_tag_d;
      wp_q <= wp_d;
      rp_q <= rp_d;
      ptr_q <= ptr_d;
      rvalid_q <= rvalid_d;
      rdata_q <= rdata_d;
      err_q <= err_d;
    end
  end
  always_ff @(posedge eclk) if (push) tag_mem[wp_q[PW-2:0]] <= slot_tag_q;
  assign rdata = rdata_q;
  assign rvalid = rvalid_q;
  assign rd_outstanding = cnt;
  assign err_orphan = err_q;
  assign memc_cmd_en = fire;
  assign memc_cmd_instr = {2'b00, slot_v_q & slot_rd_q};
  assign memc_cmd_bl = BL[5:0];
  assign memc_cmd_addr = slot_v_q ? slot_addr_q : '0;
  assign memc_wr_en = fire & ~slot_rd_q;
  assign memc_wr_end = 1'b1;
  assign memc_wr_mask = '0;
  assign memc_wr_data = slot_v_q ? 512'(slot_data_q) : '0;
  assign unused_bits = ^{memc_rd_data, addr_x};
endmodule

// File: tb/tb_mem_gasket_arb.sv
// tb_mem_gasket_arb: directed and random stimulus for mem_gasket_arb against a queue-based reference model
module tb_mem_gasket_arb;
  localparam int NW = 3, NR = 2, DW = 256, AW = 29, ASH = 3, TAGD = 16, BL = 1;
  localparam int N = NW + NR, OW = $clog2(TAGD) + 1;
  localparam int WAW = NW * AW, WDW = NW * DW, RAW = NR * AW;
  logic eclk = 1'b0, rstb = 1'b0;
  logic [NW-1:0] wvalid, wready;
  logic [WAW-1:0] waddr;
  logic [WDW-1:0] wdata;
  logic [NR-1:0] rsend, rready, rvalid;
  logic [RAW-1:0] raddr;
  logic [DW-1:0] rdata;
  logic [OW-1:0] rd_outstanding;
  logic err_orphan, memc_cmd_full, memc_cmd_en, memc_wr_en, memc_wr_end, memc_wr_full, memc_rd_en, memc_rd_empty;
  logic [2:0] memc_cmd_instr;
  logic [5:0] memc_cmd_bl;
  logic [27:0] memc_cmd_addr;
  logic [63:0] memc_wr_mask;
  logic [511:0] memc_wr_data, memc_rd_data;
  int total = 0, bad = 0;
  bit m_sv, m_srd, m_fire, m_err;
  logic [27:0] m_sa;
  logic [DW-1:0] m_sd, m_rd;
  logic [NR-1:0] m_rv;
  int m_st, m_rr, m_win;
  int m_tags[$];
  int dseq[$];
  int d_cnt[N];
  logic [511:0] d0, d1;
  mem_gasket_arb #(.NW(NW), .NR(NR), .DW(DW), .AW(AW), .ASH(ASH), .TAGD(TAGD), .BL(BL)) dut (
    .eclk(eclk), .rstb(rstb), .wvalid(wvalid), .wready(wready), .waddr(waddr), .wdata(wdata),
    .rsend(rsend), .rready(rready), .raddr(raddr), .rdata(rdata), .rvalid(rvalid),
    .rd_outstanding(rd_outstanding), .err_orphan(err_orphan), .memc_cmd_full(memc_cmd_full),
    .memc_cmd_en(memc_cmd_en), .memc_cmd_instr(memc_cmd_instr), .memc_cmd_bl(memc_cmd_bl),
    .memc_cmd_addr(memc_cmd_addr), .memc_wr_en(memc_wr_en), .memc_wr_end(memc_wr_end),
    .memc_wr_mask(memc_wr_mask), .memc_wr_data(memc_wr_data), .memc_wr_full(memc_wr_full),
    .memc_rd_en(memc_rd_en), .memc_rd_data(memc_rd_data), .memc_rd_empty(memc_rd_empty));
  always #5 eclk = ~eclk;
  function automatic logic [511:0] rnd512();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction
  task automatic chk(string tag, logic [511:0] obs, logic [511:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic m_reset();
    m_sv = 0;
    m_srd = 0;
    m_tags.delete();
    m_rr = N - 1;
    m_rv = '0;
    m_rd = '0;
    m_err = 0;
  endtask
  // model of one cycle: channel ring scanned cyclically from the index after the last winner
  task automatic predict();
    bit take, room, pop;
    int c;
    logic [N-1:0] req;
    req = {rsend, wvalid};
    m_fire = m_sv && !memc_cmd_full && (m_srd || !memc_wr_full);
    pop = !memc_rd_empty && m_tags.size() > 0;
    take = !m_sv || m_fire;
    room = m_tags.size() + int'(m_fire && m_srd) - int'(pop) < TAGD;
    m_win = -1;
    for (int k = 1; k <= N; k++) begin
      c = (m_rr + k) % N;
      if (m_win < 0 && take && 1'(req >> c) && (c < NW || room)) m_win = c;
    end
  endtask
  task automatic check_all();
    logic [N-1:0] eg, g;
    eg = m_win >= 0 ? N'(1) << m_win : '0;
    g = {rready, wready};
    for (int i = 0; i < N; i++) if (1'(g >> i)) begin
      d_cnt[i]++;
      dseq.push_back(i);
    end
    chk("wready", wready, eg[NW-1:0]);
    chk("rready", rready, eg[N-1:NW]);
    chk("cmd_en", memc_cmd_en, m_fire);
    chk("wr_en", memc_wr_en, m_fire && !m_srd);
    chk("instr", memc_cmd_instr, m_sv && m_srd);
    chk("cmd_addr", memc_cmd_addr, m_sv ? m_sa : 28'h0);
    chk("wr_data", memc_wr_data, m_sv ? m_sd : '0);
    chk("rd_en", memc_rd_en, !memc_rd_empty);
    chk("rvalid", rvalid, m_rv);
    chk("rdata", rdata, m_rd);
    chk("err_orphan", err_orphan, m_err);
    chk("rd_outstanding", rd_outstanding, m_tags.size());
  endtask
  task automatic update();
    int t;
    logic [63:0] a;
    if (!memc_rd_empty && m_tags.size() == 0) m_err = 1;
    if (!memc_rd_empty && m_tags.size() > 0) begin
      t = m_tags.pop_front();
      m_rv = NR'(1) << t;
      m_rd = memc_rd_data[DW-1:0];
    end else m_rv = '0;
    if (m_fire && m_srd) m_tags.push_back(m_st);
    if (m_win >= 0) begin
      m_sv = 1;
      m_srd = m_win >= NW;
      m_rr = m_win;
      if (m_srd) begin
        m_st = m_win - NW;
        a = 64'(AW'(raddr >> ((m_win - NW) * AW))) << ASH;
        m_sd = '0;
      end else begin
        a = 64'(AW'(waddr >> (m_win * AW))) << ASH;
        m_sd = DW'(wdata >> (m_win * DW));
      end
      m_sa = a[27:0];
    end else if (m_fire) m_sv = 0;
  endtask
  task automatic tick();
    @(negedge eclk);
    predict();
    check_all();
    @(posedge eclk);
    update();
    #1;
  endtask
  task automatic rst_chk();
    chk("rst_outstanding", rd_outstanding, 0);
    chk("rst_err", err_orphan, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_cmd_en", memc_cmd_en, 0);
    chk("rst_wr_en", memc_wr_en, 0);
    chk("rst_instr", memc_cmd_instr, 0);
    chk("rst_addr", memc_cmd_addr, 0);
    chk("rst_wr_data", memc_wr_data, 0);
    chk("rst_bl", memc_cmd_bl, BL);
    chk("rst_wr_end", memc_wr_end, 1);
    chk("rst_mask", memc_wr_mask, 0);
  endtask
  task automatic do_reset();
    wvalid = '0;
    rsend = '0;
    memc_cmd_full = 0;
    memc_wr_full = 0;
    memc_rd_empty = 1;
    #2 rstb = 0;
    m_reset();
    @(negedge eclk);
    rst_chk();
    @(posedge eclk);
    #1 rstb = 1;
  endtask
  task automatic drain();
    wvalid = '0;
    rsend = '0;
    memc_cmd_full = 0;
    memc_wr_full = 0;
    for (int k = 0; k < 100 && (m_sv || m_tags.size() > 0); k++) begin
      memc_rd_empty = m_tags.size() == 0;
      memc_rd_data = rnd512();
      tick();
    end
    total++;
    assert (!m_sv && m_tags.size() == 0) else begin
      bad++;
      $error("FAIL drain_timeout observed=%0d expected=0", m_tags.size());
    end
    memc_rd_empty = 1;
  endtask
  initial begin
    wvalid = '0; rsend = '0; waddr = '0; wdata = '0; raddr = '0;
    memc_cmd_full = 0; memc_wr_full = 0; memc_rd_empty = 1; memc_rd_data = '0;
    #1 do_reset();
    waddr[AW +: AW] = 29'h10;
    wdata[DW +: DW] = 256'hAB;
    wvalid = 3'b010;
    #1 chk("tp1_wready", wready, 3'b010);
    tick();
    wvalid = '0;
    #1 chk("tp1_cmd_en", memc_cmd_en, 1);
    chk("tp1_instr", memc_cmd_instr, 0);
    chk("tp1_addr", memc_cmd_addr, 28'h80);
    chk("tp1_data", memc_wr_data, 512'hAB);
    chk("tp1_wr_en", memc_wr_en, 1);
    tick();
    do_reset();
    waddr = WAW'(rnd512()); wdata = WDW'({rnd512(), rnd512()}); raddr = RAW'(rnd512());
    wvalid = '1; rsend = '1;
    dseq.delete();
    for (int i = 0; i < N; i++) d_cnt[i] = 0;
    repeat (25) tick();
    chk("rr_len", dseq.size(), 25);
    for (int i = 0; i < N; i++) chk("rr_share", d_cnt[i], 5);
    for (int k = 0; k < dseq.size(); k++) chk("rr_order", dseq[k], k % N);
    drain();
    wvalid = 3'b001; memc_cmd_full = 1; waddr = WAW'(rnd512()); wdata = WDW'({rnd512(), rnd512()});
    tick();
    wvalid = 3'b100; rsend = 2'b01;
    for (int k = 0; k < 4; k++) begin
      #1 chk("stall_ready", {rready, wready}, 0);
      chk("stall_cmd_en", memc_cmd_en, 0);
      tick();
    end
    memc_cmd_full = 0;
    #1 chk("unstall_cmd_en", memc_cmd_en, 1);
    chk("unstall_wr_en", memc_wr_en, 1);
    tick();
    drain();
    wvalid = 3'b100; memc_wr_full = 1;
    tick();
    wvalid = '0; rsend = 2'b10;
    for (int k = 0; k < 3; k++) begin
      #1 chk("wrfull_rready", rready, 0);
      chk("wrfull_cmd_en", memc_cmd_en, 0);
      tick();
    end
    memc_wr_full = 0;
    #1 chk("wrfree_cmd_en", memc_cmd_en, 1);
    chk("wrfree_rready", rready, 2'b10);
    tick();
    rsend = '0; memc_wr_full = 1;
    #1 chk("rd_wrfull_en", memc_cmd_en, 1);
    chk("rd_wrfull_instr", memc_cmd_instr, 1);
    tick();
    drain();
    raddr = RAW'(rnd512()); rsend = 2'b01;
    tick();
    rsend = 2'b10;
    tick();
    chk("ord_out1", rd_outstanding, 1);
    rsend = '0;
    tick();
    chk("ord_out2", rd_outstanding, 2);
    d0 = rnd512(); d1 = rnd512();
    memc_rd_empty = 0; memc_rd_data = d0;
    tick();
    chk("ord_rvalid0", rvalid, 2'b01);
    chk("ord_rdata0", rdata, d0[DW-1:0]);
    chk("ord_out3", rd_outstanding, 1);
    memc_rd_data = d1;
    tick();
    chk("ord_rvalid1", rvalid, 2'b10);
    chk("ord_rdata1", rdata, d1[DW-1:0]);
    chk("ord_out4", rd_outstanding, 0);
    memc_rd_empty = 1;
    tick();
    chk("ord_rvalid_clr", rvalid, 0);
    rsend = 2'b01;
    repeat (20) tick();
    chk("tagfull_out", rd_outstanding, TAGD);
    #1 chk("tagfull_rready", rready, 0);
    memc_rd_empty = 0; memc_rd_data = rnd512();
    #1 chk("tagpop_rready", rready, 2'b01);
    tick();
    drain();
    memc_rd_empty = 0;
    #1 chk("orphan_pre", err_orphan, 0);
    tick();
    chk("orphan_set", err_orphan, 1);
    memc_rd_empty = 1;
    tick();
    chk("orphan_sticky", err_orphan, 1);
    do_reset();
    rsend = 2'b01;
    repeat (3) tick();
    do_reset();
    memc_rd_empty = 0; memc_rd_data = rnd512();
    tick();
    chk("stale_orphan", err_orphan, 1);
    do_reset();
    for (int c = 0; c < 400; c++) begin
      wvalid = NW'($urandom); rsend = NR'($urandom);
      waddr = WAW'(rnd512()); wdata = WDW'({rnd512(), rnd512()}); raddr = RAW'(rnd512());
      memc_cmd_full = $urandom_range(3) == 0;
      memc_wr_full = $urandom_range(3) == 0;
      memc_rd_empty = m_tags.size() == 0 ? $urandom_range(19) != 0 : $urandom_range(1) == 0;
      memc_rd_data = rnd512();
      tick();
    end
    drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
